uart_instruction_rx: RTL and testbench



---
 rtl/uart_instruction_rx.sv | 131 +++++++++++++
 tb/tb_uart_instruction_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_instruction_rx.sv
// UART 8N1 receiver that packs four little-endian bytes into a 32-bit
// instruction word and strobes it out for one cycle on completion.
module uart_instruction_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_rx,
  output logic [31:0] o_instruction,
  output logic        o_data_received,
  output logic        o_frame_error,
  output logic [1:0]  o_byte_count,
  output logic        o_debug_flag
);

  localparam logic [15:0] HALF_LAST    = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_LAST     = 16'(CLKS_PER_BIT - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, state_next;
  logic        rx_meta, rx_s, armed;
  logic [15:0] timer;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;
  logic [23:0] word;
  logic [31:0] idle_cnt;
  logic        start_det, half_tick, bit_tick;

  assign half_tick    = (timer == HALF_LAST);
  assign bit_tick     = (timer == BIT_LAST);
  assign o_debug_flag = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // armed blocks a new start until the line has been seen high after a frame
  always_comb begin
    state_next = state;
    start_det  = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s && armed) begin
          state_next = START;
          start_det  = 1'b1;
        end
      end
      START: if (half_tick) state_next = rx_s ? IDLE : DATA;
      DATA:  if (bit_tick && bit_idx == 3'd7) state_next = STOP;
      STOP:  if (bit_tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta         <= 1'b1;
      rx_s            <= 1'b1;
      armed           <= 1'b1;
      timer           <= '0;
      bit_idx         <= '0;
      shift           <= '0;
      word            <= '0;
      idle_cnt        <= '0;
      o_instruction   <= '0;
      o_data_received <= 1'b0;
      o_frame_error   <= 1'b0;
      o_byte_count    <= '0;
    end else begin
      rx_meta         <= i_rx;
      rx_s            <= rx_meta;
      o_data_received <= 1'b0;
      o_frame_error   <= 1'b0;
      timer           <= timer + 16'd1;
      case (state)
        IDLE: begin
          timer <= '0;
          if (rx_s) armed <= 1'b1;
          if (start_det || o_byte_count == 2'd0) begin
            idle_cnt <= '0;
          end else if (idle_cnt == TIMEOUT_LAST) begin
            idle_cnt     <= '0;
            o_byte_count <= '0;
          end else begin
            idle_cnt <= idle_cnt + 32'd1;
          end
        end
        START: begin
          if (half_tick) begin
            timer   <= '0;
            bit_idx <= '0;
          end
        end
        DATA: begin
          if (bit_tick) begin
            timer   <= '0;
            shift   <= {rx_s, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            timer <= '0;
            armed <= rx_s;
            if (rx_s) begin
              o_byte_count <= o_byte_count + 2'd1;
              case (o_byte_count)
                2'd0: word[7:0]   <= shift;
                2'd1: word[15:8]  <= shift;
                2'd2: word[23:16] <= shift;
                default: begin
                  o_instruction   <= {shift, word};
                  o_data_received <= 1'b1;
                end
              endcase
            end else begin
              o_frame_error <= 1'b1;
              o_byte_count  <= '0;
            end
          end
        end
        default: timer <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_instruction_rx.sv
// Directed and randomized bench for uart_instruction_rx, checked against a
// byte-queue model of the little-endian word assembly.
module tb_uart_instruction_rx;

  localparam int CPB = 4;
  localparam int TOB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_rx = 1'b1;
  logic [31:0] o_instruction;
  logic        o_data_received, o_frame_error, o_debug_flag;
  logic [1:0]  o_byte_count;

  int passed = 0;
  int total  = 0;

  logic [7:0]  m_bytes[$];
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  int          fe_exp = 0;
  int          fe_obs = 0;
  int          coincide = 0;
  int          stray = 0;
  logic [31:0] last_instr = '0;

  uart_instruction_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .i_rx(i_rx),
    .o_instruction(o_instruction), .o_data_received(o_data_received),
    .o_frame_error(o_frame_error), .o_byte_count(o_byte_count),
    .o_debug_flag(o_debug_flag)
  );

  always #5 clk = ~clk;

  // Pulse monitor; o_instruction may only move on a completion strobe
  always @(negedge clk) begin
    if (rst) begin
      if (o_data_received) obs_q.push_back(o_instruction);
      if (o_frame_error) fe_obs++;
      if (o_data_received && o_frame_error) coincide++;
      if (o_instruction !== last_instr && !o_data_received) stray++;
    end
    last_instr = o_instruction;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive_bit(input logic v);
    i_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    if (stop_bit) begin
      m_bytes.push_back(b);
      if (m_bytes.size() == 4) begin
        exp_q.push_back({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]});
        m_bytes.delete();
      end
    end else begin
      m_bytes.delete();
      fe_exp++;
      i_rx = 1'b1;
    end
  endtask

  task automatic check_output(input string tag);
    repeat (2) @(negedge clk);
    check({tag, "_count"}, 32'(o_byte_count), 32'(m_bytes.size()));
    check({tag, "_pulses"}, 32'(obs_q.size()), 32'(exp_q.size()));
    check({tag, "_ferr"}, 32'(fe_obs), 32'(fe_exp));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic send_word(input logic [31:0] w, input string tag);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], 1'b1);
      check_output(tag);
    end
  endtask

  initial begin
    logic [31:0] w;
    logic [7:0]  b;
    logic        sb;

    $display("[TB] reset");
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      i_rx = ~i_rx;
    end
    check("rst_instr", o_instruction, 32'h0);
    check("rst_flags", {29'h0, o_data_received, o_frame_error, o_debug_flag}, 32'h0);
    check("rst_count", 32'(o_byte_count), 32'h0);
    i_rx = 1'b1;
    rst  = 1'b1;
    repeat (4) @(negedge clk);

    $display("[TB] single word");
    send_word(32'h00210233, "single");
    check("single_last", o_instruction, 32'h00210233);

    $display("[TB] back-to-back words");
    w = 32'h00208293;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    w = 32'h00319213;
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    check_output("b2b");
    check("b2b_last", o_instruction, 32'h00319213);

    $display("[TB] false start");
    i_rx = 1'b0;
    @(negedge clk);
    i_rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    check_output("glitch");
    check("glitch_idle", 32'(o_debug_flag), 32'h0);

    $display("[TB] frame error");
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    check_output("fe_pre");
    send_byte(8'h33, 1'b0);
    check_output("fe");
    repeat (CPB) @(negedge clk);

    $display("[TB] timeout");
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    check_output("to_pre");
    repeat (20 * CPB) @(negedge clk);
    m_bytes.delete();
    check_output("to_idle");
    send_word(32'h0022A423, "to_word");

    $display("[TB] reset mid-frame");
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    i_rx = 1'b1;
    rst  = 1'b0;
    #1;
    check("mid_instr", o_instruction, 32'h0);
    check("mid_count", 32'(o_byte_count), 32'h0);
    check("mid_debug", 32'(o_debug_flag), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_bytes.delete();
    repeat (3 * CPB) @(negedge clk);
    send_word(32'h00210233, "mid_word");

    $display("[TB] randomized bytes");
    for (int i = 0; i < 24; i++) begin
      b  = 8'($urandom);
      sb = ($urandom_range(0, 7) != 0);
      send_byte(b, sb);
      check_output("rand");
      repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
    end

    check("no_coincide", 32'(coincide), 32'h0);
    check("no_stray_update", 32'(stray), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
